i2s_rx_10xe: RTL and testbench

I2S receiver in master mode: generates the serial bit clock and word-select from the audio master clock, deserialises 24-bit left/right samples from the serial data line, and presents them as an AXI-Stream master. It is the receive-side counterpart of the I2S transmitter core. It sits between an external I2S codec/ADC (or the transmitter in loopback) and the audio AXI-Stream fabric.

---
 rtl/i2s_rx_10xe.sv | 163 ++++++++++++++++
 tb/tb_i2s_rx_10xe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_10xe.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_10xe
// Purpose  : I2S master-mode receiver. Generates SCLK/LRCLK from aud_mclk,
//            deserialises MSB-first samples and emits them on AXI-Stream
//            through a 2-entry FIFO with a sticky overflow flag.
// Options  : I2S_RX_10XE_SIGN_EXT_EN - sign-extend tdata above the sample
//            (default: zero-extend).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_10xe #(
  parameter int AUD_WIDTH             = 24,
  parameter int AXI_STREAM_DATA_WIDTH = 32,
  parameter int AXI_STREAM_TID_WIDTH  = 3
) (
  input  logic                             aud_mclk,
  input  logic                             aud_mrst_n,
  input  logic                             ctrl_en,
  input  logic [7:0]                       cfg_sclk_div,
  input  logic                             ovf_clr,
  input  logic                             sdata_in,
  output logic                             sclk_out,
  output logic                             lrclk_out,
  output logic [AXI_STREAM_DATA_WIDTH-1:0] m_axis_aud_tdata,
  output logic [AXI_STREAM_TID_WIDTH-1:0]  m_axis_aud_tid,
  output logic                             m_axis_aud_tlast,
  output logic                             m_axis_aud_tvalid,
  input  logic                             m_axis_aud_tready,
  output logic                             ovf
);

  localparam logic [4:0] LAST_SLOT = 5'(AUD_WIDTH);
  localparam int         ENTRY_W   = AUD_WIDTH + 1;

  // Bit-clock divider and slot framing
  logic [7:0]           div_cnt;
  logic [7:0]           div_cur;
  logic [7:0]           div_eff;
  logic                 div_tc;
  logic [4:0]           bit_cnt;
  logic [AUD_WIDTH-1:0] shreg;
  logic [AUD_WIDTH-1:0] shift_next;
  logic                 rise_ev;
  logic                 capture;
  logic                 word_done;

  // Completed word waiting one cycle before entering the FIFO
  logic                 push_pend;
  logic [ENTRY_W-1:0]   push_data;

  // Output FIFO
  logic [ENTRY_W-1:0]   mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;
  logic [ENTRY_W-1:0]   head;
  logic [AUD_WIDTH-1:0] head_sample;

  // A divisor of 0 behaves as 1
  assign div_eff    = (cfg_sclk_div == 8'd0) ? 8'd1 : cfg_sclk_div;
  assign div_tc     = (div_cnt == div_cur - 8'd1);
  assign rise_ev    = div_tc && !sclk_out;
  assign capture    = rise_ev && (bit_cnt != 5'd0) && (bit_cnt <= LAST_SLOT);
  assign word_done  = rise_ev && (bit_cnt == LAST_SLOT);
  assign shift_next = {shreg[AUD_WIDTH-2:0], sdata_in};

  // Divider, SCLK/LRCLK generation and serial capture; disable holds it idle
  always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
    if (!aud_mrst_n) begin
      div_cnt   <= 8'd0;
      div_cur   <= 8'd1;
      sclk_out  <= 1'b0;
      lrclk_out <= 1'b0;
      bit_cnt   <= 5'd0;
      shreg     <= '0;
    end else if (!ctrl_en) begin
      div_cnt   <= 8'd0;
      div_cur   <= div_eff;
      sclk_out  <= 1'b0;
      lrclk_out <= 1'b0;
      bit_cnt   <= 5'd0;
      shreg     <= '0;
    end else if (div_tc) begin
      div_cnt  <= 8'd0;
      div_cur  <= div_eff;
      sclk_out <= ~sclk_out;
      if (sclk_out) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          lrclk_out <= ~lrclk_out;
        end
      end else if (capture) begin
        shreg <= shift_next;
      end
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Stage the finished word so it lands in the FIFO on the following edge
  always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
    if (!aud_mrst_n) begin
      push_pend <= 1'b0;
      push_data <= '0;
    end else begin
      push_pend <= ctrl_en && word_done;
      push_data <= {shift_next, lrclk_out};
    end
  end

  assign full    = (count == 2'd2);
  assign pop     = m_axis_aud_tvalid && m_axis_aud_tready;
  assign push_ok = push_pend && (!full || pop);
  assign drop    = push_pend && full && !pop;

  // FIFO storage, pointers, occupancy and sticky overflow (drop beats clear)
  always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
    if (!aud_mrst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign head_sample = head[ENTRY_W-1:1];

  assign m_axis_aud_tvalid = (count != 2'd0);
  assign m_axis_aud_tid    = AXI_STREAM_TID_WIDTH'(head[0]);
  assign m_axis_aud_tlast  = head[0];
`ifdef I2S_RX_10XE_SIGN_EXT_EN
  assign m_axis_aud_tdata  = AXI_STREAM_DATA_WIDTH'($signed(head_sample));
`else
  assign m_axis_aud_tdata  = AXI_STREAM_DATA_WIDTH'(head_sample);
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_10xe.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_10xe
// Purpose  : Self-checking bench for i2s_rx_10xe. A codec model drives
//            sdata_in from sample tables on SCLK falling edges; a scoreboard
//            of expected words is compared with every AXI-Stream transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_10xe;

  logic        aud_mclk   = 1'b0;
  logic        aud_mrst_n = 1'b0;
  logic        ctrl_en    = 1'b0;
  logic [7:0]  cfg_sclk_div = 8'd1;
  logic        ovf_clr    = 1'b0;
  logic        sdata_in   = 1'b1;
  logic        tready     = 1'b1;
  logic        sclk_out;
  logic        lrclk_out;
  logic [31:0] tdata;
  logic [2:0]  tid;
  logic        tlast;
  logic        tvalid;
  logic        ovf;

  i2s_rx_10xe #(
    .AUD_WIDTH(24), .AXI_STREAM_DATA_WIDTH(32), .AXI_STREAM_TID_WIDTH(3)
  ) dut (
    .aud_mclk(aud_mclk), .aud_mrst_n(aud_mrst_n), .ctrl_en(ctrl_en),
    .cfg_sclk_div(cfg_sclk_div), .ovf_clr(ovf_clr), .sdata_in(sdata_in),
    .sclk_out(sclk_out), .lrclk_out(lrclk_out),
    .m_axis_aud_tdata(tdata), .m_axis_aud_tid(tid), .m_axis_aud_tlast(tlast),
    .m_axis_aud_tvalid(tvalid), .m_axis_aud_tready(tready), .ovf(ovf)
  );

  always #5 aud_mclk = ~aud_mclk;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  id;
    logic        last;
  } word_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  word_t       exp_q[$];
  word_t       e_w;
  logic [31:0] rx_data [0:63];
  logic [2:0]  rx_id   [0:63];
  logic        rx_last [0:63];
  int          rx_n = 0;
  logic [23:0] tx_mem  [0:31];
  int          tx_base = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] ext(input logic [23:0] s);
`ifdef I2S_RX_10XE_SIGN_EXT_EN
    return {{8{s[23]}}, s};
`else
    return {8'h00, s};
`endif
  endfunction

  function automatic word_t mk(input logic [23:0] s, input logic ch);
    return {ext(s), {2'b00, ch}, ch};
  endfunction

  // Slot k since frame start: word k/32, channel alternates, bits MSB first
  // in slots 1..24; every other slot carries a 1 that must be ignored.
  function automatic logic slot_bit(input int kk);
    int          s;
    logic [23:0] w;
    s = kk % 32;
    w = tx_mem[tx_base + kk / 32];
    if (s >= 1 && s <= 24) return w[24 - s];
    return 1'b1;
  endfunction

  // Codec model: advance the slot on every SCLK falling edge
  int   k = 0;
  logic cprev = 1'b0;
  always @(negedge aud_mclk) begin
    if (!aud_mrst_n || !ctrl_en) begin
      k = 0;
      cprev = 1'b0;
      sdata_in = 1'b1;
    end else begin
      if (cprev && !sclk_out) k = k + 1;
      cprev = sclk_out;
      sdata_in = slot_bit(k);
    end
  end

  // Scoreboard, hold-stability and clock period monitor
  int          cyc = 0;
  int          last_sr = -1, last_lr = -1, sclk_per = 0, lr_per = 0;
  logic        ps = 1'b0, pl = 1'b0;
  logic        stall_prev = 1'b0;
  logic [35:0] held = '0;
  always @(negedge aud_mclk) begin
    cyc++;
    if (aud_mrst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got tdata %0h tid %0h, expected no word", tdata, tid);
      end else begin
        e_w = exp_q.pop_front();
        check("axis_word", {tdata, tid, tlast}, e_w);
      end
      rx_data[rx_n % 64] = tdata;
      rx_id[rx_n % 64]   = tid;
      rx_last[rx_n % 64] = tlast;
      rx_n++;
    end
    if (aud_mrst_n && stall_prev)
      check("hold_stable", {tvalid, tdata, tid, tlast}, {1'b1, held});
    stall_prev = aud_mrst_n && tvalid && !tready;
    held = {tdata, tid, tlast};
    if (!aud_mrst_n || !ctrl_en) begin
      last_sr = -1;
      last_lr = -1;
    end else begin
      if (sclk_out && !ps) begin
        if (last_sr >= 0) sclk_per = cyc - last_sr;
        last_sr = cyc;
      end
      if (lrclk_out && !pl) begin
        if (last_lr >= 0) lr_per = cyc - last_lr;
        last_lr = cyc;
      end
    end
    ps = sclk_out;
    pl = lrclk_out;
  end

  task automatic tick();
    @(posedge aud_mclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sclk"},   sclk_out,  0);
    check({tag, "_lrclk"},  lrclk_out, 0);
    check({tag, "_tdata"},  tdata,     0);
    check({tag, "_tid"},    tid,       0);
    check({tag, "_tlast"},  tlast,     0);
    check({tag, "_tvalid"}, tvalid,    0);
    check({tag, "_ovf"},    ovf,       0);
  endtask

  // Start a frame (enable or reset release), check first-word latency,
  // run 200*D cycles, disable mid-word and check periods and drain.
  task automatic run_phase(input logic [7:0] div, input int base, input int dval,
                           input bit via_reset);
    int cnt;
    cfg_sclk_div = div;
    tx_base = base;
    sclk_per = 0;
    lr_per = 0;
    tick();
    if (via_reset) aud_mrst_n = 1'b1;
    else ctrl_en = 1'b1;
    cnt = 0;
    do begin
      @(posedge aud_mclk);
      cnt++;
      @(negedge aud_mclk);
    end while (!tvalid && cnt < 5000);
    check("first_word_latency", cnt, 49 * dval + 1);
    repeat (200 * dval - cnt) @(posedge aud_mclk);
    #1 ctrl_en = 1'b0;
    tick();
    tick();
    check("disabled_sclk", sclk_out, 0);
    check("disabled_lrclk", lrclk_out, 0);
    check("sclk_period", sclk_per, 2 * dval);
    check("lrclk_period", lr_per, 128 * dval);
    repeat (60) tick();
    check("all_words_delivered", exp_q.size(), 0);
  endtask

  initial begin
    int r0;
    tx_mem[0]  = 24'hA5A5A5; tx_mem[1]  = 24'h5A5A5A; tx_mem[2]  = 24'h800001; tx_mem[3]  = 24'hFFFFFF;
    tx_mem[4]  = 24'h123456; tx_mem[5]  = 24'hFEDCBA; tx_mem[6]  = 24'h7FFFFF; tx_mem[7]  = 24'h0F0F0F;
    tx_mem[8]  = 24'hC3C3C3; tx_mem[9]  = 24'h3C3C3C; tx_mem[10] = 24'h000001; tx_mem[11] = 24'hF0F0F0;
    tx_mem[12] = 24'h000001; tx_mem[13] = 24'h000002; tx_mem[14] = 24'h000003; tx_mem[15] = 24'h000004;
    tx_mem[16] = 24'h000777; tx_mem[17] = 24'hFFFFFF; tx_mem[18] = 24'hFFFFFF; tx_mem[19] = 24'hFFFFFF;
    tx_mem[20] = 24'h0000FF; tx_mem[21] = 24'h00ABCD; tx_mem[22] = 24'h555555; tx_mem[23] = 24'hAAAAAA;
    for (int i = 24; i < 32; i++) tx_mem[i] = 24'h111111;

    repeat (3) @(posedge aud_mclk);
    #1 check_reset_vals("reset");
    aud_mrst_n = 1'b1;

    // D = 1 framing, including the sign-extension sample
    exp_q.push_back(mk(24'hA5A5A5, 1'b0));
    exp_q.push_back(mk(24'h5A5A5A, 1'b1));
    exp_q.push_back(mk(24'h800001, 1'b0));
    run_phase(8'd1, 0, 1, 1'b0);
    check("lit_w0_tdata", rx_data[0], 32'h00A5A5A5);
    check("lit_w0_tid", rx_id[0], 0);
    check("lit_w0_tlast", rx_last[0], 0);
    check("lit_w1_tdata", rx_data[1], 32'h005A5A5A);
    check("lit_w1_tid", rx_id[1], 1);
    check("lit_w1_tlast", rx_last[1], 1);
`ifdef I2S_RX_10XE_SIGN_EXT_EN
    check("lit_sign_ext", rx_data[2], 32'hFF800001);
`else
    check("lit_zero_ext", rx_data[2], 32'h00800001);
`endif

    // D = 3 and D = 0 (same as 1)
    exp_q.push_back(mk(24'h123456, 1'b0));
    exp_q.push_back(mk(24'hFEDCBA, 1'b1));
    exp_q.push_back(mk(24'h7FFFFF, 1'b0));
    run_phase(8'd3, 4, 3, 1'b0);
    exp_q.push_back(mk(24'hC3C3C3, 1'b0));
    exp_q.push_back(mk(24'h3C3C3C, 1'b1));
    exp_q.push_back(mk(24'h000001, 1'b0));
    run_phase(8'd0, 8, 1, 1'b0);

    // Backpressure: third word dropped, ovf set, then drain and clear
    cfg_sclk_div = 8'd1;
    tx_base = 12;
    tready = 1'b0;
    exp_q.push_back(mk(24'h000001, 1'b0));
    exp_q.push_back(mk(24'h000002, 1'b1));
    tick();
    ctrl_en = 1'b1;
    repeat (200) tick();
    ctrl_en = 1'b0;
    tick();
    tick();
    check("bp_ovf_set", ovf, 1);
    check("bp_tvalid_held", tvalid, 1);
    check("bp_head_tdata", tdata, 32'h00000001);
    check("bp_head_tid", tid, 0);
    r0 = rx_n;
    tready = 1'b1;
    repeat (5) tick();
    check("bp_drained_count", rx_n - r0, 2);
    check("bp_first_out", rx_data[r0 % 64], 32'h00000001);
    check("bp_second_out", rx_data[(r0 + 1) % 64], 32'h00000002);
    check("bp_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    check("bp_ovf_cleared", ovf, 0);
    ovf_clr = 1'b0;
    tick();

    // Reset mid-frame with a word parked in the FIFO
    tready = 1'b0;
    tx_base = 16;
    ctrl_en = 1'b1;
    repeat (88) tick();
    check("prereset_tvalid", tvalid, 1);
    check("prereset_lrclk", lrclk_out, 1);
    #1 aud_mrst_n = 1'b0;
    #1 check_reset_vals("midreset");
    tready = 1'b1;
    r0 = rx_n;
    exp_q.push_back(mk(24'h0000FF, 1'b0));
    exp_q.push_back(mk(24'h00ABCD, 1'b1));
    exp_q.push_back(mk(24'h555555, 1'b0));
    tick();
    run_phase(8'd1, 20, 1, 1'b1);
    check("post_reset_tid", rx_id[r0 % 64], 0);
    check("post_reset_tdata", rx_data[r0 % 64], 32'h000000FF);

    // Disable mid-word: nothing pushed, clocks parked low
    tx_base = 24;
    cfg_sclk_div = 8'd1;
    ctrl_en = 1'b1;
    repeat (30) tick();
    ctrl_en = 1'b0;
    r0 = rx_n;
    tick();
    check("dis_sclk", sclk_out, 0);
    check("dis_lrclk", lrclk_out, 0);
    repeat (100) tick();
    check("dis_tvalid", tvalid, 0);
    check("dis_no_word", rx_n - r0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
